// File: rtl/xtbm_arbiter_pkg.sv
// Shared encodings for the xfer_buffer <-> TBM port arbiter:
// transfer modes, arbiter states and the default watchdog limit.
package xtbm_arbiter_pkg;

   typedef enum logic [1:0] {
      XTBM_NOTHING = 2'd0,
      XTBM_WRITING = 2'd1,
      XTBM_READING = 2'd2
   } xtbm_mode_e;

   typedef enum logic [1:0] {
      XARB_IDLE = 2'd0,
      XARB_XFER = 2'd1,
      XARB_TURN = 2'd2
   } xarb_state_e;

   localparam int XTBM_TIMEOUT = 1024;

   function automatic int wdog_width(input int t);
      return $clog2(t) + 1;
   endfunction

endpackage

// File: rtl/xtbm_watchdog.sv
// Clear/enable cycle counter that saturates at TIMEOUT_CYCLES-1 and
// flags expiry there; TIMEOUT_CYCLES = 0 never expires.
module xtbm_watchdog
   import xtbm_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = XTBM_TIMEOUT
) (
   input  logic clk,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = wdog_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIM =
      (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Count holds k-1 on the k-th XFER edge, so expiry lands on edge T.
   assign o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LIM);

endmodule

// File: rtl/xtbm_arbiter.sv
// Shares the single xfer_buffer <-> TBM port between the write and
// read requesters, one transfer at a time, with a watchdog abort.
module xtbm_arbiter
   import xtbm_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = XTBM_TIMEOUT
) (
   input  logic              clock_fpga,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              xfer_buf_select,
   output logic              mwrite_enable,
   output logic [ADDR_W-1:0] tbm_address,
   input  logic              xfer_complete,
   output logic [1:0]        xtbm_mode,
   output logic              xfer_timeout,
   output logic              busy
);

   xarb_state_e       r_state, w_nxt_state;
   xtbm_mode_e        r_mode, w_nxt_mode;
   xtbm_mode_e        r_last, w_nxt_last;
   logic              r_sel, w_nxt_sel;
   logic              r_mwe, w_nxt_mwe;
   logic [ADDR_W-1:0] r_addr, w_nxt_addr;
   logic              r_wr_ack, w_nxt_wr_ack;
   logic              r_rd_ack, w_nxt_rd_ack;
   logic              r_tmo, w_nxt_tmo;
   logic              r_busy;
   logic              w_pick_wr;
   logic              w_expire;

   xtbm_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (clock_fpga),
      .i_clear (reset || (r_state != XARB_XFER)),
      .i_en    (r_state == XARB_XFER),
      .o_expire(w_expire)
   );

   // Contention goes to the mode opposite the last grant.
   assign w_pick_wr = wr_req && (!rd_req || (r_last == XTBM_READING));

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_mode   = r_mode;
      w_nxt_last   = r_last;
      w_nxt_sel    = r_sel;
      w_nxt_mwe    = r_mwe;
      w_nxt_addr   = r_addr;
      w_nxt_wr_ack = 1'b0;
      w_nxt_rd_ack = 1'b0;
      w_nxt_tmo    = 1'b0;
      unique case (r_state)
         XARB_IDLE: begin
            if (wr_req || rd_req) begin
               w_nxt_state = XARB_XFER;
               w_nxt_sel   = 1'b1;
               w_nxt_mwe   = w_pick_wr;
               if (w_pick_wr) begin
                  w_nxt_addr = wr_addr;
                  w_nxt_mode = XTBM_WRITING;
                  w_nxt_last = XTBM_WRITING;
               end else begin
                  w_nxt_addr = rd_addr;
                  w_nxt_mode = XTBM_READING;
                  w_nxt_last = XTBM_READING;
               end
            end
         end
         XARB_XFER: begin
            if (xfer_complete || w_expire) begin
               w_nxt_state  = XARB_TURN;
               w_nxt_sel    = 1'b0;
               w_nxt_mwe    = 1'b0;
               w_nxt_mode   = XTBM_NOTHING;
               w_nxt_wr_ack = r_mwe;
               w_nxt_rd_ack = !r_mwe;
               w_nxt_tmo    = !xfer_complete;
            end
         end
         XARB_TURN: begin
            w_nxt_state = XARB_IDLE;
         end
         default: begin
            w_nxt_state = XARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_fpga) begin
      if (reset) begin
         r_state  <= XARB_IDLE;
         r_mode   <= XTBM_NOTHING;
         r_last   <= XTBM_READING;
         r_sel    <= 1'b0;
         r_mwe    <= 1'b0;
         r_addr   <= '0;
         r_wr_ack <= 1'b0;
         r_rd_ack <= 1'b0;
         r_tmo    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_mode   <= w_nxt_mode;
         r_last   <= w_nxt_last;
         r_sel    <= w_nxt_sel;
         r_mwe    <= w_nxt_mwe;
         r_addr   <= w_nxt_addr;
         r_wr_ack <= w_nxt_wr_ack;
         r_rd_ack <= w_nxt_rd_ack;
         r_tmo    <= w_nxt_tmo;
         r_busy   <= (w_nxt_state != XARB_IDLE);
      end
   end

   assign wr_ack          = r_wr_ack;
   assign rd_ack          = r_rd_ack;
   assign xfer_buf_select = r_sel;
   assign mwrite_enable   = r_mwe;
   assign tbm_address     = r_addr;
   assign xtbm_mode       = r_mode;
   assign xfer_timeout    = r_tmo;
   assign busy            = r_busy;

endmodule

// File: tb/tb_xtbm_arbiter.sv
// Scoreboard bench for xtbm_arbiter: directed cases plus random rounds
// against a transaction-level model of grant order and ack outcome.
module tb_xtbm_arbiter;

   localparam int AW  = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_req = 1'b0;
   logic          rd_req = 1'b0;
   logic          cpl = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          wr_ack, rd_ack, sel, mwe, tmo, busy;
   logic [AW-1:0] taddr;
   logic [1:0]    mode;

   xtbm_arbiter #(
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock_fpga     (clk),
      .reset          (rst),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_ack         (wr_ack),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_ack         (rd_ack),
      .xfer_buf_select(sel),
      .mwrite_enable  (mwe),
      .tbm_address    (taddr),
      .xfer_complete  (cpl),
      .xtbm_mode      (mode),
      .xfer_timeout   (tmo),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
   } grant_t;

   typedef struct {
      bit wr;
      bit to;
      int len;
   } ack_t;

   grant_t g_q[$];
   ack_t   a_q[$];
   int     lat_q[$];
   int     n_chk = 0;
   int     n_fail = 0;
   bit     last_wr = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic push_xfer(input bit wr, input logic [AW-1:0] a,
                            input int lat);
      g_q.push_back('{wr: wr, addr: a});
      a_q.push_back('{wr: wr, to: (lat > TMO),
                      len: (lat > TMO) ? TMO : lat});
      lat_q.push_back(lat);
   endtask

   // Model: a lone request is granted; contention serves the mode
   // opposite the previous grant first, then the other one.
   task automatic issue(input bit w, input bit r, input logic [AW-1:0] wa,
                        input logic [AW-1:0] ra, input int wl, input int rl);
      wr_addr = wa;
      rd_addr = ra;
      wr_req  = w;
      rd_req  = r;
      if (w && r) begin
         if (!last_wr) begin
            push_xfer(1'b1, wa, wl);
            push_xfer(1'b0, ra, rl);
            last_wr = 1'b0;
         end else begin
            push_xfer(1'b0, ra, rl);
            push_xfer(1'b1, wa, wl);
            last_wr = 1'b1;
         end
      end else if (w) begin
         push_xfer(1'b1, wa, wl);
         last_wr = 1'b1;
      end else begin
         push_xfer(1'b0, ra, rl);
         last_wr = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((wr_req || rd_req || busy) && (t < 300)) begin
         @(negedge clk);
         if (wr_ack) wr_req = 1'b0;
         if (rd_ack) rd_req = 1'b0;
         t++;
      end
      check("drain_bound", (t < 300), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel"}, sel, 0);
      check({tag, "_mwe"}, mwe, 0);
      check({tag, "_addr"}, taddr, 0);
      check({tag, "_mode"}, mode, 0);
      check({tag, "_wr_ack"}, wr_ack, 0);
      check({tag, "_rd_ack"}, rd_ack, 0);
      check({tag, "_tmo"}, tmo, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Datapath responder: completes after the queued latency, and
   // throws random spurious completes while no transfer is active.
   int rsp_k = 0;
   int rsp_l = 0;
   bit rsp_psel = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         cpl = 1'b0;
      end else if (sel) begin
         if (!rsp_psel) begin
            rsp_k = 0;
            rsp_l = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
         end
         rsp_k++;
         cpl = (rsp_k == rsp_l);
      end else begin
         cpl = ($urandom_range(0, 3) == 0);
      end
      rsp_psel = sel;
   end

   // Monitor: grants and acks are popped and compared as they appear.
   bit mon_psel = 1'b0;
   bit mon_pack = 1'b0;
   int mon_len = 0;
   always @(negedge clk) begin
      grant_t g;
      ack_t   a;
      if (!rst) begin
         check("ack_exclusive", (wr_ack && rd_ack), 0);
         if (mon_pack) check("turn_no_select", sel, 0);
         if (sel && !mon_psel) begin
            mon_len = 0;
            if (g_q.size() == 0) begin
               check("unexpected_grant", 1, 0);
            end else begin
               g = g_q.pop_front();
               check("grant_mode", mode, g.wr ? 1 : 2);
               check("grant_mwe", mwe, g.wr);
               check("grant_addr", taddr, g.addr);
            end
         end
         if (sel) mon_len++;
         if (wr_ack || rd_ack) begin
            if (a_q.size() == 0) begin
               check("unexpected_ack", 1, 0);
            end else begin
               a = a_q.pop_front();
               check("ack_wr", wr_ack, a.wr);
               check("ack_rd", rd_ack, !a.wr);
               check("ack_timeout", tmo, a.to);
               check("xfer_len", mon_len, a.len);
               check("ack_sel_low", sel, 0);
               check("ack_mode", mode, 0);
            end
         end else if (tmo) begin
            check("stray_timeout", tmo, 0);
         end
      end
      mon_psel = sel;
      mon_pack = wr_ack || rd_ack;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation bound expired");
      $fatal(1, "global timeout");
   end

   initial begin
      int t;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 5, 1);
      drain();

      issue(1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 2, 2);
      drain();
      issue(1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 2, 2);
      drain();

      issue(1'b0, 1'b1, 32'h0, 32'h0000_4000, 100, 100);
      drain();
      issue(1'b1, 1'b0, 32'h0000_5000, 32'h0, 3, 1);
      drain();

      issue(1'b1, 1'b0, 32'h0000_6000, 32'h0, TMO, 1);
      drain();

      issue(1'b1, 1'b0, 32'h0000_7000, 32'h0, 100, 1);
      t = 0;
      while (!sel && (t < 20)) begin
         @(negedge clk);
         t++;
      end
      check("reset_test_grant", sel, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      void'(a_q.pop_back());
      @(negedge clk);
      check_all_zero("mid_reset");
      rst = 1'b0;
      last_wr = 1'b0;
      issue(1'b1, 1'b1, 32'h0000_8000, 32'h0000_9000, 4, 6);
      drain();

      for (int i = 0; i < 40; i++) begin
         bit w, r;
         w = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 1) == 1);
         if (!w && !r) w = 1'b1;
         issue(w, r, $urandom, $urandom,
               $urandom_range(1, 20), $urandom_range(1, 20));
         drain();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("grants_left", g_q.size(), 0);
      check("acks_left", a_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/xtbm_arbiter.md
Name: xtbm_arbiter

Overview:
- Owns the single xfer_buffer <-> TBM port and shares it between two requesters.
  - Write requester: the command processor moving host write data into TBM.
  - Read requester: the command-closing path moving TBM data out to the host.
- Grants one 4KB transfer at a time and drives xfer_buf_select, mwrite_enable and tbm_address.
- Waits for xfer_complete, or a watchdog timeout, then acks the requester.
- Alternates WRITING/READING mode when both requesters contend, and inserts a one-cycle NOTHING turnaround between transfers.

Parameters:
- ADDR_W, 32, width of tbm_address and requester addresses.
- TIMEOUT_CYCLES, 1024, cycles in XFER before abort; 0 disables the watchdog.

Ports:
- clock_fpga  in  1  block clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_req  in  1  write requester wants one transfer; held until wr_ack.
- wr_addr  in  ADDR_W  TBM address for the write; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse: write transfer finished or aborted.
- rd_req  in  1  read requester wants one transfer; held until rd_ack.
- rd_addr  in  ADDR_W  TBM address for the read.
- rd_ack  out  1  one-cycle pulse: read transfer finished or aborted.
- xfer_buf_select  out  1  transfer active toward the xfer buffer.
- mwrite_enable  out  1  1 = buffer->TBM (write), 0 = TBM->buffer (read); valid while xfer_buf_select is high.
- tbm_address  out  ADDR_W  latched address of the granted transfer.
- xfer_complete  in  1  datapath reports the current transfer is done.
- xtbm_mode  out  2  XTBM_NOTHING / XTBM_WRITING / XTBM_READING.
- xfer_timeout  out  1  one-cycle pulse coincident with the ack of an aborted transfer.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, takes effect at the next edge):
  - All outputs go to 0; xtbm_mode = XTBM_NOTHING.
  - state = IDLE; last_mode = XTBM_READING; watchdog cleared.
  - A transfer in flight is abandoned with no ack.
- States: IDLE, XFER, TURN; all outputs are registered.
- IDLE:
  - Only wr_req high -> grant write. Only rd_req high -> grant read.
  - Both high -> grant the mode opposite last_mode. After reset, the first contested grant is therefore WRITE.
  - On grant, at the edge:
    - Latch the address into tbm_address.
    - Set xfer_buf_select = 1 and mwrite_enable = (write).
    - Set xtbm_mode to WRITING or READING and set last_mode to the granted mode.
    - Clear the watchdog and go to XFER.
  - Latency: a req sampled high at edge N gives select high in the cycle after edge N.
  - xfer_complete is ignored in IDLE.
- XFER:
  - Outputs are held stable; changes on req or addr are ignored. The watchdog increments each cycle.
  - xfer_complete sampled 1 at edge M:
    - After M: xfer_buf_select = 0, mwrite_enable = 0, xtbm_mode = NOTHING.
    - The granted requester's ack = 1 for one cycle; go to TURN.
  - Watchdog reaches TIMEOUT_CYCLES without xfer_complete (TIMEOUT_CYCLES != 0):
    - Deassert the same way and pulse both the ack and xfer_timeout for one cycle; go to TURN.
  - If complete and timeout occur on the same edge, complete wins and xfer_timeout stays 0.
- TURN:
  - One cycle with xtbm_mode = NOTHING; xfer_complete is ignored; go to IDLE.
  - The requester drops req at the edge ending TURN, so IDLE never re-grants a finished request.
  - A requester still high in IDLE is treated as a new request.
- Throughput: at most one transfer per 3 + (complete latency) cycles.
- Watchdog width: clog2(TIMEOUT_CYCLES)+1 bits, saturating, with no wrap.
- Invariants:
  - wr_ack and rd_ack are never high together.
  - xfer_buf_select is never high in IDLE or TURN.

Decomposition:
- hd_parameter.vh holds:
  - XTBM_NOTHING, XTBM_WRITING, XTBM_READING (existing).
  - New state encodings XARB_IDLE, XARB_XFER, XARB_TURN.
  - Default XTBM_TIMEOUT.
- One sub-module, xtbm_watchdog: clear/enable counter with a saturating expire output, parameterised by TIMEOUT_CYCLES. The arbiter FSM stays in xtbm_arbiter.

Test Plan:
- Single write: wr_req=1, wr_addr=0x0000_1000; complete 5 cycles after select -> select=1, mwrite_enable=1, tbm_address=0x1000, xtbm_mode=WRITING; wr_ack pulses 1 cycle after complete; rd_ack and xfer_timeout stay 0.
- Contention after reset: wr_req and rd_req high together, addrs 0x2000 and 0x3000, each completed after 2 cycles -> grant order W(0x2000), R(0x3000), W, R alternating; one NOTHING cycle between each pair.
- Timeout: TIMEOUT_CYCLES=16, rd_req=1, xfer_complete never asserted -> select drops after 16 XFER cycles; rd_ack=1 and xfer_timeout=1 in the same cycle; next request is granted normally.
- Reset mid-XFER: assert reset 3 cycles into a write -> all outputs 0 next cycle, no wr_ack; after release with both reqs high, write is granted first.
- Spurious complete: pulse xfer_complete in IDLE and in TURN -> no ack, no state change.
- Complete on the timeout edge: TIMEOUT_CYCLES=4, complete asserted exactly at expiry -> wr_ack=1, xfer_timeout=0.
